// File: rtl/key_enc_pkg.sv
// Shared types and constants for the key_encoder_148 front-panel key encoder.
// Holds the FSM state encoding and the 8-to-3 priority-encode helper.
package key_enc_pkg;

    localparam int CODE_W = 3;
    localparam int KEY_W  = 8;
    localparam logic [KEY_W-1:0] KEYS_RELEASED = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } key_state_e;

    // Index of the highest active-low (0) bit; bit KEY_W-1 wins.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [KEY_W-1:0] keys_n);
        logic [CODE_W-1:0] result;
        result = {CODE_W{1'b0}};
        for (int i = 0; i < KEY_W; i++) begin
            if (keys_n[i] == 1'b0) begin
                result = CODE_W'(i);
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus whole-vector debounce for active-low key lines.
// A new vector is accepted only after DEBOUNCE_CYCLES consecutive unchanged samples.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int KEY_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_n,
    output logic [KEY_W-1:0] stable_n,
    output logic             gs_n
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [KEY_W-1:0] meta_r;
    logic [KEY_W-1:0] sync_r;
    logic [KEY_W-1:0] prev_r;
    logic [KEY_W-1:0] stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             gs_n_r;

    // Synchronise, then accept sync_r once it has stayed put long enough; gs_n tracks stable_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r   <= {KEY_W{1'b1}};
            sync_r   <= {KEY_W{1'b1}};
            prev_r   <= {KEY_W{1'b1}};
            stable_r <= {KEY_W{1'b1}};
            cnt_r    <= {CNT_W{1'b0}};
            gs_n_r   <= 1'b1;
        end else begin
            meta_r <= key_n;
            sync_r <= meta_r;
            prev_r <= sync_r;
            if (sync_r != prev_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (sync_r == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_r <= sync_r;
                gs_n_r   <= &sync_r;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stable_n = stable_r;
    assign gs_n     = gs_n_r;

endmodule

// File: rtl/key_encoder_148.sv
// Clocked 8-to-3 priority key encoder with debounce, press FSM and a one-entry valid/ready slot.
// Optional held-key auto-repeat is built when KEY_ENC_REPEAT_EN is defined.
module key_encoder_148
    import key_enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_n,
    input  logic              ready,
    input  logic              ovf_clr,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              gs_n,
    output logic              overflow
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("key_encoder_148: DEBOUNCE_CYCLES and REPEAT_CYCLES must both be at least 2");
    end

    logic [KEY_W-1:0]  stable_n_s;
    logic              any_s;
    logic [CODE_W-1:0] enc_s;
    logic              event_s;
    logic              rpt_hit_s;
    logic              drop_s;
    key_state_e        state_r;
    key_state_e        next_state_s;
    logic [CODE_W-1:0] last_code_r;
    logic [CODE_W-1:0] code_r;
    logic              valid_r;
    logic              overflow_r;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_W           (KEY_W)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .stable_n (stable_n_s),
        .gs_n     (gs_n)
    );

    assign any_s  = ~(&stable_n_s);
    assign enc_s  = prio_enc(stable_n_s);
    assign drop_s = event_s & valid_r & ~ready;

`ifdef KEY_ENC_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES);
    logic [RPT_W-1:0] rpt_cnt_r;

    // Clocks since the last event while the same key stays held; cleared by any event or leaving HELD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_r <= {RPT_W{1'b0}};
        end else if (event_s || state_r != HELD) begin
            rpt_cnt_r <= {RPT_W{1'b0}};
        end else begin
            rpt_cnt_r <= rpt_cnt_r + {{(RPT_W-1){1'b0}}, 1'b1};
        end
    end

    assign rpt_hit_s = (rpt_cnt_r == RPT_W'(REPEAT_CYCLES - 1));
`else
    assign rpt_hit_s = 1'b0;
`endif

    // Press FSM: new press or priority change raises an event; release is silent.
    always_comb begin
        event_s      = 1'b0;
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    next_state_s = HELD;
                    event_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            HELD: begin
                if (!any_s) begin
                    next_state_s = IDLE;
                end else if (enc_s != last_code_r) begin
                    event_s = 1'b1;
                end else begin
                    event_s = rpt_hit_s;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state and the code of the most recently raised event (dropped or not).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_code_r <= {CODE_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (event_s) begin
                last_code_r <= enc_s;
            end else begin
                last_code_r <= last_code_r;
            end
        end
    end

    // One-entry output slot; a full, unaccepted slot keeps its code and drops the new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r  <= {CODE_W{1'b0}};
            valid_r <= 1'b0;
        end else if (event_s && (!valid_r || ready)) begin
            code_r  <= enc_s;
            valid_r <= 1'b1;
        end else if (!event_s && valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Sticky drop flag; a drop in the same cycle as ovf_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign code     = code_r;
    assign valid    = valid_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_key_encoder_148.sv
// Directed bench for key_encoder_148 with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Repeat-specific expectations follow KEY_ENC_REPEAT_EN when it is defined.
module tb_key_encoder_148;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_n;
    logic       ready;
    logic       ovf_clr;
    logic [2:0] code;
    logic       valid;
    logic       gs_n;
    logic       overflow;

    int checks;
    int failures;
    int ev_total;
    int ev_base;

    key_encoder_148 #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .ready    (ready),
        .ovf_clr  (ovf_clr),
        .code     (code),
        .valid    (valid),
        .gs_n     (gs_n),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes seen at the clock edge (pre-update values)
    initial ev_total = 0;
    always @(posedge clk) begin
        if (rst_n && valid && ready) ev_total = ev_total + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        key_n    = 8'hFF;
        ready    = 1'b0;
        ovf_clr  = 1'b0;
        ev_base  = 0;

        // Reset state
        step(2);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_gs_n", 32'(gs_n), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Single press of bit 2: one-cycle valid pulse at t+7
        ev_base = ev_total;
        ready = 1'b1;
        key_n = 8'hFB;
        step(7);
        chk("press_valid_early", 32'(valid), 32'd0);
        chk("press_gs_n", 32'(gs_n), 32'd0);
        step(1);
        chk("press_valid", 32'(valid), 32'd1);
        chk("press_code", 32'(code), 32'd2);
        step(1);
        chk("press_valid_pulse", 32'(valid), 32'd0);
        chk("press_events", 32'(ev_total - ev_base), 32'd1);
`ifdef KEY_ENC_REPEAT_EN
        step(7);
        chk("repeat_valid", 32'(valid), 32'd1);
        chk("repeat_code", 32'(code), 32'd2);
`else
        step(20);
        chk("no_repeat_events", 32'(ev_total - ev_base), 32'd1);
`endif
        key_n = 8'hFF;
        step(7);
        chk("release_gs_n", 32'(gs_n), 32'd1);
        step(3);
        chk("release_silent", 32'(valid), 32'd0);

        // Bit 5 bouncing every 3 clocks, then held
        ev_base = ev_total;
        for (int i = 0; i < 7; i++) begin
            key_n = (i % 2 == 0) ? 8'hDF : 8'hFF;
            step(3);
        end
        chk("bounce_gs_n_before", 32'(gs_n), 32'd1);
        step(6);
        chk("bounce_events", 32'(ev_total - ev_base), 32'd1);
        chk("bounce_code", 32'(code), 32'd5);

        // Priority changes: bit 2, add bit 6, drop bit 6
        key_n = 8'hFF;
        step(12);
        chk("pri_release_gs_n", 32'(gs_n), 32'd1);
        ev_base = ev_total;
        key_n = 8'hFB;
        step(12);
        chk("pri_code_2", 32'(code), 32'd2);
        key_n = 8'hBB;
        step(12);
        chk("pri_code_6", 32'(code), 32'd6);
        key_n = 8'hFB;
        step(12);
        chk("pri_code_back_2", 32'(code), 32'd2);
        chk("pri_gs_n", 32'(gs_n), 32'd0);
`ifndef KEY_ENC_REPEAT_EN
        chk("pri_events", 32'(ev_total - ev_base), 32'd3);
`endif

        // Overflow with consumer stalled
        key_n = 8'hFF;
        step(12);
        ready = 1'b0;
        key_n = 8'hFD;
        step(12);
        chk("ovf_first_valid", 32'(valid), 32'd1);
        chk("ovf_first_code", 32'(code), 32'd1);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        key_n = 8'hED;
        step(12);
        chk("ovf_code_held", 32'(code), 32'd1);
        chk("ovf_valid_held", 32'(valid), 32'd1);
        chk("ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // New event in the same cycle the held one is accepted
        key_n = 8'hAD;
        step(7);
        chk("handoff_valid_before", 32'(valid), 32'd1);
        chk("handoff_code_before", 32'(code), 32'd1);
        ready = 1'b1;
        step(1);
        chk("handoff_valid", 32'(valid), 32'd1);
        chk("handoff_code", 32'(code), 32'd6);
        step(1);
        chk("handoff_drained", 32'(valid), 32'd0);
        chk("handoff_code_kept", 32'(code), 32'd6);

        // Reset while a key is held, then re-issue
        key_n = 8'hFF;
        step(12);
        key_n = 8'hF7;
        step(12);
        chk("hold3_code", 32'(code), 32'd3);
        chk("hold3_gs_n", 32'(gs_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_code", 32'(code), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_gs_n", 32'(gs_n), 32'd1);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(7);
        chk("reissue_early", 32'(valid), 32'd0);
        chk("reissue_gs_n", 32'(gs_n), 32'd0);
        step(1);
        chk("reissue_valid", 32'(valid), 32'd1);
        chk("reissue_code", 32'(code), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
